// File: rtl/wb_stage_ps.sv
// Writeback stage: M/W pipeline register, load-response wait, sub-word load
// alignment/extension, register-file write port and retire counter.
module wb_stage_ps #(
  parameter  int DATA_W = 32,
  parameter  int RA_W   = 5,
  parameter  int CNT_W  = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic [1:0]        m_wb_sel,
  input  logic [1:0]        m_ld_size,
  input  logic              m_ld_signed,
  input  logic [OFF_W-1:0]  m_byte_off,
  input  logic [RA_W-1:0]   m_wra,
  input  logic [DATA_W-1:0] m_alu,
  input  logic [31:0]       m_pc,
  input  logic              m_is_eret,
  input  logic              dm_rsp_valid,
  input  logic [DATA_W-1:0] dm_rsp_data,
  input  logic              int_req,
  output logic              w_ready,
  output logic              wd_we,
  output logic [RA_W-1:0]   wd_wra,
  output logic [DATA_W-1:0] wd_wrd,
  output logic [31:0]       wd_pc,
  output logic              w_is_eret,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_WRITE} st_t;

  st_t               st_q, st_d;
  logic [1:0]        sel_q, size_q;
  logic              sgn_q, eret_q, rsp_err_q;
  logic [OFF_W-1:0]  off_q;
  logic [RA_W-1:0]   wra_q;
  logic [DATA_W-1:0] alu_q, mem_q;
  logic [31:0]       pc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic kill, cap, rsp_take;

  // A kill only exists when something is resident; int_req in EMPTY just blocks capture.
  assign kill     = int_req && (st_q != S_EMPTY);
  assign w_ready  = (st_q == S_EMPTY) || (st_q == S_WRITE);
  assign cap      = m_valid && w_ready && !int_req;
  assign rsp_take = (st_q == S_WAIT) && dm_rsp_valid && !int_req;

  always_comb begin
    st_d = S_EMPTY;
    if (kill)
      st_d = S_EMPTY;
    else if (cap)
      st_d = (m_wb_sel == 2'b01) ? S_WAIT : S_WRITE;
    else if (st_q == S_WAIT)
      st_d = dm_rsp_valid ? S_WRITE : S_WAIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= S_EMPTY;
      sel_q     <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      off_q     <= '0;
      wra_q     <= '0;
      alu_q     <= '0;
      pc_q      <= '0;
      eret_q    <= 1'b0;
      mem_q     <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      st_q <= st_d;
      if (cap) begin
        sel_q  <= m_wb_sel;
        size_q <= m_ld_size;
        sgn_q  <= m_ld_signed;
        off_q  <= m_byte_off;
        wra_q  <= m_wra;
        alu_q  <= m_alu;
        pc_q   <= m_pc;
        eret_q <= m_is_eret;
      end
      if (rsp_take)
        mem_q <= dm_rsp_data;
      if (dm_rsp_valid && (st_q != S_WAIT) && !kill)
        rsp_err_q <= 1'b1;
      if ((st_q == S_WRITE) && !int_req)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Load field extraction: shift the selected lane down to bit 0, then extend.
  logic [OFF_W-1:0]  sh;
  logic [DATA_W-1:0] shifted, ld_val, pc8_ext;
  logic [31:0]       pc8;

  always_comb begin
    case (size_q)
      2'b00:   sh = off_q;
      2'b01:   sh = off_q & ~OFF_W'(1);
      default: sh = off_q & ~OFF_W'(3);
    endcase
  end

  assign shifted = mem_q >> {sh, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   ld_val = sgn_q ? DATA_W'(signed'(shifted[7:0]))  : DATA_W'(shifted[7:0]);
      2'b01:   ld_val = sgn_q ? DATA_W'(signed'(shifted[15:0])) : DATA_W'(shifted[15:0]);
      2'b10:   ld_val = sgn_q ? DATA_W'(signed'(shifted[31:0])) : DATA_W'(shifted[31:0]);
      default: ld_val = mem_q;
    endcase
  end

  // Link address wraps at 32 bits before widening.
  assign pc8     = pc_q + 32'd8;
  assign pc8_ext = DATA_W'(pc8);

  always_comb begin
    case (sel_q)
      2'b01:   wd_wrd = ld_val;
      2'b10:   wd_wrd = pc8_ext;
      default: wd_wrd = alu_q;
    endcase
  end

  assign wd_we      = (st_q == S_WRITE) && (wra_q != '0) && !int_req;
  assign wd_wra     = wra_q;
  assign wd_pc      = pc_q;
  assign w_is_eret  = (st_q == S_WRITE) && eret_q;
  assign rsp_err    = rsp_err_q;
  assign retire_cnt = cnt_q;

endmodule
